// File: rtl/truth_table_sweeper.sv
// Drives A..D through all 16 vectors, waits SETTLE cycles on each, then captures F into tt.
// Optional EXPECT_CHECK_EN adds a golden-table compare (expected in, err out).
//
// state  | meaning
// IDLE   | waiting for start; outputs and tt hold
// APPLY  | vector idx on A..D, counting settle cycles
// SAMPLE | capture F into tt[idx], advance or finish
// DONE   | one-cycle done pulse
module truth_table_sweeper #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef EXPECT_CHECK_EN
  ,
  input  logic [15:0] expected,
  output logic        err
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_d, done_d;
  logic [15:0] tt_d;
`ifdef EXPECT_CHECK_EN
  logic        err_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy;
    done_d  = 1'b0;
    tt_d    = tt;
`ifdef EXPECT_CHECK_EN
    err_d   = err;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          vec_d   = 4'd0;
          tt_d    = 16'h0000;
          busy_d  = 1'b1;
`ifdef EXPECT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[idx_q] = F;
        if (idx_q == 4'hF) begin
          state_d = DONE;
          vec_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef EXPECT_CHECK_EN
          // Compare against the table including the bit captured this edge.
          err_d   = (tt_d != expected);
`endif
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 4'd1;
          cnt_d   = 8'd0;
          vec_d   = idx_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      vec_q   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt      <= 16'h0000;
`ifdef EXPECT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy    <= busy_d;
      done    <= done_d;
      tt      <= tt_d;
`ifdef EXPECT_CHECK_EN
      err     <= err_d;
`endif
    end
  end

  assign {A, B, C, D} = vec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: SETTLE=4 and SETTLE=1 instances, scoreboarded tt.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic fmode = 1'b0;
  logic [15:0] exp_reg = 16'hAAAA;

  logic a0, b0, c0, d0, busy0, done0, f0;
  logic a1, b1, c1, d1, busy1, done1, f1;
  logic [15:0] tt0, tt1;
  logic err0, err1;

  logic [3:0]  vec;
  logic        busy, done;
  logic [15:0] tt;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  assign f0 = fmode ? (a0 & b0) : d0;
  assign f1 = ~a1;

  assign vec  = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign tt   = sel ? tt1 : tt0;

  truth_table_sweeper #(.SETTLE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .F(f0),
    .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0), .tt(tt0)
`ifdef EXPECT_CHECK_EN
    , .expected(exp_reg), .err(err0)
`endif
  );

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .F(f1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1), .tt(tt1)
`ifdef EXPECT_CHECK_EN
    , .expected(16'h00FF), .err(err1)
`endif
  );

`ifndef EXPECT_CHECK_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge just after the start-accept edge; leaves at the negedge after DONE->IDLE.
  task automatic sweep_body(input int settle, input int pulse_at, input logic hold);
    int k;
    int len;
    len = 16 * (settle + 1);
    k = 0;
    check("busy_rise", 16'(busy), 16'd1);
    while (done !== 1'b1 && k < len + 20) begin
      check("vector", 16'(vec), 16'(k / (settle + 1)));
      check("busy_high", 16'(busy), 16'd1);
      start = hold | (k == pulse_at);
      @(negedge clk);
      k++;
    end
    start = hold;
    check("done_latency", 16'(k), 16'(len));
    check("busy_fall", 16'(busy), 16'd0);
    check("vec_zero_at_done", 16'(vec), 16'd0);
    if (sb.size() > 0) check("tt", tt, sb.pop_front());
    else check("scoreboard_empty", 16'd0, 16'd1);
    @(negedge clk);
    check("done_one_cycle", 16'(done), 16'd0);
    check("busy_idle", 16'(busy), 16'd0);
  endtask

  task automatic run_sweep(input logic [15:0] exp_tt, input int settle, input int pulse_at);
    @(negedge clk);
    start = 1'b1;
    sb.push_back(exp_tt);
    @(negedge clk);
    start = 1'b0;
    sweep_body(settle, pulse_at, 1'b0);
  endtask

  initial begin
    // Reset with start asserted: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy0), 16'd0);
    check("rst_done", 16'(done0), 16'd0);
    check("rst_vec", 16'({a0, b0, c0, d0}), 16'd0);
    check("rst_tt", tt0, 16'h0000);
    check("rst_err", 16'(err0), 16'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 16'(busy0), 16'd0);

    // F = D, plus an ignored start pulse at cycle 30.
    fmode = 1'b0;
    run_sweep(16'hAAAA, 4, 30);
    check("err_match", 16'(err0), 16'd0);

    // F = A&B.
    fmode = 1'b1;
    run_sweep(16'hF000, 4, -1);
    repeat (3) @(negedge clk);
    check("tt_hold", tt0, 16'hF000);

    // Held-high start: back-to-back sweeps with one IDLE cycle between.
    fmode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(16'hAAAA);
    @(negedge clk);
    sweep_body(4, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    sb.push_back(16'hAAAA);
    sweep_body(4, -1, 1'b0);

    // Reset at cycle 40 of a sweep.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_vec", 16'(vec), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_tt", tt, 16'h0000);
    check("abort_done", 16'(done), 16'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (90) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
      end
      check("no_done_after_abort", 16'(seen), 16'd0);
    end
    run_sweep(16'hAAAA, 4, -1);

`ifdef EXPECT_CHECK_EN
    exp_reg = 16'hAAAB;
    run_sweep(16'hAAAA, 4, -1);
    check("err_mismatch", 16'(err0), 16'd1);
    repeat (5) @(negedge clk);
    check("err_hold", 16'(err0), 16'd1);
    exp_reg = 16'hAAAA;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(16'hAAAA);
    @(negedge clk);
    start = 1'b0;
    check("err_clear_on_start", 16'(err0), 16'd0);
    sweep_body(4, -1, 1'b0);
    check("err_rematch", 16'(err0), 16'd0);
`endif

    // SETTLE=1, F = ~A.
    sel = 1'b1;
    run_sweep(16'h00FF, 1, -1);
    check("err_settle1", 16'(err1), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus stage that sits directly upstream of the lab's 4-input combinational logic blocks (reduced SOP/POS implementations). It drives the A, B, C, D inputs of the logic under test through all 16 combinations in ascending order. It waits a programmable settle time on each vector, then samples the function output F back into a 16-bit truth-table register. The board can then display or self-check the captured truth table without a simulator.

## Interface
- SETTLE, default 4: cycles each vector is held before F is sampled; legal range 1..255.
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  sweep request; acted on only in IDLE.
- F  in  1  function output of the downstream combinational block.
- A  out  1  vector bit 3 (MSB), registered.
- B  out  1  vector bit 2, registered.
- C  out  1  vector bit 1, registered.
- D  out  1  vector bit 0 (LSB), registered.
- busy  out  1  high while a sweep is in APPLY/SAMPLE.
- done  out  1  one-cycle pulse when the sweep completes.
- tt  out  16  captured truth table; tt[i] = F for vector i = {A,B,C,D}.
- expected  in  16  golden truth table; present only with EXPECT_CHECK_EN.
- err  out  1  mismatch flag; present only with EXPECT_CHECK_EN.

## Operation
- The block is a four-state FSM: IDLE, APPLY, SAMPLE, DONE. It uses a 4-bit vector index idx and an 8-bit settle counter cnt.
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, idx=0, cnt=0;
  - A=B=C=D=0;
  - busy=0, done=0, tt=16'h0000 (and err=0 when EXPECT_CHECK_EN is defined).
- IDLE:
  - start=1 → APPLY, with idx=0, cnt=0, tt cleared to 0, {A,B,C,D}=4'b0000, busy=1.
  - start=0 → stay in IDLE; outputs hold.
- APPLY:
  - {A,B,C,D} holds idx.
  - cnt increments each cycle.
  - When cnt==SETTLE-1 → SAMPLE.
- SAMPLE:
  - tt[idx] <= F.
  - If idx==15 → DONE, with busy=0 and {A,B,C,D}=4'b0000.
  - Otherwise idx <= idx+1, cnt <= 0, {A,B,C,D} <= idx+1, → APPLY.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge → IDLE, with done=0.
- idx never wraps mid-sweep. The 15→DONE transition is the only exit from the sweep.
- start is ignored in APPLY, SAMPLE and DONE. A held-high start produces a new sweep on the first IDLE cycle after DONE.
- tt holds its value from DONE until the next accepted start.
- rst_n=0 mid-sweep aborts immediately to the reset values; the partial tt is discarded.
- rst_n has priority over start when both are active at the same edge.

## Timing
- Let t0 be the edge at which start is accepted in IDLE.
- Vector i appears on A..D after edge t0 + i·(SETTLE+1).
- F for vector i is sampled at edge t0 + i·(SETTLE+1) + SETTLE + 1. The downstream logic therefore gets SETTLE full cycles to settle.
- DONE is entered at edge t0 + 16·(SETTLE+1). For SETTLE=4 this is 80 cycles after t0.
- done is high for the cycle following that edge. tt is final in the same cycle done is high.
- busy rises at t0 and falls at the DONE-entry edge.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- EXPECT_CHECK_EN defined:
  - Adds the expected input and the err output.
  - At the DONE-entry edge, err <= (final tt != expected), including the last bit sampled at that edge.
  - err is cleared on accepted start and on reset.
  - err holds until the next start.
- EXPECT_CHECK_EN undefined:
  - The expected and err ports do not exist.
  - There is no comparison logic; all other behaviour is identical.

## Test plan
- Reset, then start pulse, with SETTLE=4 and F=D → tt=16'hAAAA. done pulses exactly once, 80 cycles after the start edge. busy is high for exactly 80 cycles.
- F = A&B → tt=16'hF000. A..D step 0000→1111, each vector held 5 cycles, and return to 0000 at DONE.
- Pulse start again while busy (at cycle 30) → ignored. Only one done pulse; result unchanged. start held high → back-to-back sweeps with one IDLE cycle between them.
- Assert rst_n=0 at cycle 40 of a sweep → next cycle has A..D=0, busy=0, tt=0. No done pulse. A following start completes a normal sweep.
- With EXPECT_CHECK_EN, F=D and expected=16'hAAAA → err=0 with done. Repeat with expected=16'hAAAB → err=1, held until the next start.
- With SETTLE=1 and F=~A → tt=16'h00FF, and done arrives 32 cycles after start.
